// File: rtl/alu_stage_pkg.sv
// rtl/alu_stage_pkg.sv - shared state encoding and op codes for serial_alu_stage
package alu_stage_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ADD      = 2'd1,
        DONE     = 2'd2,
        NOT_DONE = 2'd3
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_NOT = 1'b1;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - 1-bit full adder used by the bit-serial add path
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_alu_stage.sv
// rtl/serial_alu_stage.sv - execute stage: single-cycle NOT, bit-serial LSB-first ADD
module serial_alu_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] not_res,
    output logic [N-1:0] add_res,
    output logic         sel,
    output logic         cout,
    output logic         ovf
);

    import alu_stage_pkg::*;

    localparam int CW = $clog2(N);

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   sa;
    logic [N-1:0]   sb;
    logic           c;
    logic           sign_a;
    logic           sign_b;
    logic           fa_s;
    logic           fa_c;
    logic           last_bit;
    logic           accept;

    assign last_bit = (cnt == CW'(N - 1));
    assign accept   = (state == IDLE) && start;

    full_adder u_fa (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (c),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (op == OP_NOT) ? NOT_DONE : ADD;
                end
            end
            ADD: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE, NOT_DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Results persist across ops of the other type so the downstream mux sees stable inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            sa      <= '0;
            sb      <= '0;
            c       <= 1'b0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            not_res <= '0;
            add_res <= '0;
            sel     <= 1'b0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            if (op == OP_NOT) begin
                not_res <= ~a;
                sel     <= 1'b1;
            end else begin
                sa     <= a;
                sb     <= b;
                c      <= 1'b0;
                cnt    <= '0;
                sel    <= 1'b0;
                sign_a <= a[N-1];
                sign_b <= b[N-1];
            end
        end else if (state == ADD) begin
            add_res <= {fa_s, add_res[N-1:1]};
            sa      <= {1'b0, sa[N-1:1]};
            sb      <= {1'b0, sb[N-1:1]};
            c       <= fa_c;
            cnt     <= cnt + 1'b1;
            if (last_bit) begin
                cout <= fa_c;
                ovf  <= (sign_a == sign_b) && (fa_s != sign_a);
            end
        end
    end

endmodule

// File: tb/tb_serial_alu_stage.sv
// tb/tb_serial_alu_stage.sv - scoreboard bench for serial_alu_stage
module tb_serial_alu_stage;
    import alu_stage_pkg::*;

    localparam int N = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic         op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] not_res;
    logic [N-1:0] add_res;
    logic         sel;
    logic         cout;
    logic         ovf;

    typedef struct {
        logic [N-1:0] not_res;
        logic [N-1:0] add_res;
        logic         sel;
        logic         cout;
        logic         ovf;
        int           lat;
    } exp_t;

    exp_t         sbq[$];
    logic [N-1:0] m_not;
    logic [N-1:0] m_add;
    logic         m_sel;
    logic         m_cout;
    logic         m_ovf;
    int           tests;
    int           fails;

    serial_alu_stage #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .not_res (not_res),
        .add_res (add_res),
        .sel     (sel),
        .cout    (cout),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        m_not  = '0;
        m_add  = '0;
        m_sel  = 1'b0;
        m_cout = 1'b0;
        m_ovf  = 1'b0;
        sbq.delete();
    endtask

    // Drive one start pulse and push the expected post-done state.
    task automatic issue(input logic o, input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N:0] sum;
        exp_t       e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (o == OP_NOT) begin
            m_not = ~x;
            m_sel = 1'b1;
        end else begin
            sum    = {1'b0, x} + {1'b0, y};
            m_add  = sum[N-1:0];
            m_cout = sum[N];
            m_ovf  = (x[N-1] == y[N-1]) && (sum[N-1] != x[N-1]);
            m_sel  = 1'b0;
        end
        e.not_res = m_not;
        e.add_res = m_add;
        e.sel     = m_sel;
        e.cout    = m_cout;
        e.ovf     = m_ovf;
        e.lat     = (o == OP_NOT) ? 1 : N + 1;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Count cycles after the start edge until done; lat=0 means the bound expired.
    task automatic wait_done(output int lat, output bit busy_ok);
        bit got;
        got     = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 200 && !got; k++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                lat = k;
                got = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        logic [2*N+4:0] obs;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        obs = {busy, done, sel, cout, ovf, not_res, add_res};
        tests++;
        if (obs !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_not();
        int   lat;
        bit   bok;
        exp_t e;
        issue(OP_NOT, 32'h0000_00FF, 32'h1234_5678);
        wait_done(lat, bok);
        e = sbq.pop_front();
        tests++;
        if (lat != e.lat || !bok) begin
            fails++;
            $display("FAIL not_latency: got %0d busy_ok=%b expected %0d", lat, bok, e.lat);
        end
        tests++;
        if (not_res !== e.not_res || not_res !== 32'hFFFF_FF00) begin
            fails++;
            $display("FAIL not_res: got %h expected %h", not_res, e.not_res);
        end
        tests++;
        if (sel !== e.sel || add_res !== e.add_res) begin
            fails++;
            $display("FAIL not_sel_hold: sel=%b add_res=%h expected %b %h", sel, add_res, e.sel, e.add_res);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL not_return_idle: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_add(input string name, input logic [N-1:0] x, input logic [N-1:0] y);
        int   lat;
        bit   bok;
        exp_t e;
        issue(OP_ADD, x, y);
        wait_done(lat, bok);
        e = sbq.pop_front();
        tests++;
        if (lat != e.lat || !bok) begin
            fails++;
            $display("FAIL %s_latency: got %0d busy_ok=%b expected %0d", name, lat, bok, e.lat);
        end
        tests++;
        if (add_res !== e.add_res) begin
            fails++;
            $display("FAIL %s_sum: got %h expected %h", name, add_res, e.add_res);
        end
        tests++;
        if ({cout, ovf, sel} !== {e.cout, e.ovf, e.sel}) begin
            fails++;
            $display("FAIL %s_flags: cout/ovf/sel got %b%b%b expected %b%b%b",
                     name, cout, ovf, sel, e.cout, e.ovf, e.sel);
        end
        tests++;
        if (not_res !== e.not_res) begin
            fails++;
            $display("FAIL %s_not_hold: got %h expected %h", name, not_res, e.not_res);
        end
    endtask

    task automatic test_busy_ignore();
        int   lat;
        bit   bok;
        exp_t e;
        issue(OP_ADD, 32'h1357_9BDF, 32'h2468_ACE0);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = OP_NOT;
        a     = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bok);
        e = sbq.pop_front();
        tests++;
        if (lat + 5 != e.lat || !bok) begin
            fails++;
            $display("FAIL busy_latency: got %0d busy_ok=%b expected %0d", lat + 5, bok, e.lat);
        end
        tests++;
        if (add_res !== e.add_res || sel !== 1'b0 || not_res !== e.not_res) begin
            fails++;
            $display("FAIL busy_ignore: add_res=%h sel=%b not_res=%h expected %h 0 %h",
                     add_res, sel, not_res, e.add_res, e.not_res);
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        bit   bok;
        exp_t e;
        issue(OP_NOT, 32'hA5A5_0F0F, 32'h0);
        wait_done(lat, bok);
        e = sbq.pop_front();
        // start held during the done cycle must be ignored
        start = 1'b1;
        op    = OP_NOT;
        a     = 32'h0000_0001;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || not_res !== e.not_res) begin
            fails++;
            $display("FAIL done_cycle_start: busy=%b not_res=%h expected 0 %h", busy, not_res, e.not_res);
        end
        issue(OP_ADD, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
        wait_done(lat, bok);
        e = sbq.pop_front();
        tests++;
        if (lat != e.lat || add_res !== e.add_res || {cout, ovf, sel} !== {e.cout, e.ovf, e.sel}) begin
            fails++;
            $display("FAIL b2b_add: lat=%0d sum=%h flags=%b%b%b expected %0d %h %b%b%b",
                     lat, add_res, cout, ovf, sel, e.lat, e.add_res, e.cout, e.ovf, e.sel);
        end
        issue(OP_NOT, 32'h0F0F_F0F0, 32'h0);
        wait_done(lat, bok);
        e = sbq.pop_front();
        tests++;
        if (lat != e.lat || not_res !== e.not_res || sel !== 1'b1 || add_res !== e.add_res) begin
            fails++;
            $display("FAIL b2b_not: lat=%0d not_res=%h sel=%b add_res=%h expected %0d %h 1 %h",
                     lat, not_res, sel, add_res, e.lat, e.not_res, e.add_res);
        end
    endtask

    task automatic test_reset_mid();
        logic [2*N+4:0] obs;
        bit             saw_done;
        issue(OP_NOT, 32'h5555_AAAA, 32'h0);
        repeat (2) @(negedge clk);
        issue(OP_ADD, 32'h0123_4567, 32'h0765_4321);
        repeat (9) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        obs = {busy, done, sel, cout, ovf, not_res, add_res};
        tests++;
        if (obs !== '0) begin
            fails++;
            $display("FAIL reset_async: got %h expected 0", obs);
        end
        model_clear();
        @(negedge clk);
        rst      = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        tests++;
        if (saw_done) begin
            fails++;
            $display("FAIL reset_no_done: activity after reset got 1 expected 0");
        end
        test_add("post_reset", 32'd3, 32'd4);
        tests++;
        if (add_res !== 32'd7) begin
            fails++;
            $display("FAIL post_reset_value: got %h expected 7", add_res);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        model_clear();
        test_reset();
        test_not();
        test_add("add_5_7", 32'd5, 32'd7);
        test_add("uwrap", 32'hFFFF_FFFF, 32'd1);
        test_add("ovf_pos", 32'h7FFF_FFFF, 32'd1);
        test_add("ovf_neg", 32'h8000_0000, 32'h8000_0000);
        test_add("rand", 32'h9ABC_DEF0, 32'h8765_4321);
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_alu_stage.md
# serial_alu_stage

Multi-cycle execute stage that computes the two candidate results consumed by the lab-4 result multiplexer. It produces a bitwise-NOT result and an N-bit sum, plus the select bit that chooses between them. The NOT completes in one cycle; the ADD runs bit-serially, LSB first, over N cycles through a single full adder. A start/done handshake paces the stage, and the downstream mux samples `not_res`, `add_res` and `sel` when `done` pulses.

## Interface
- `N`, default 32: operand and result width (N ≥ 2).
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request; accepted only when `busy`=0.
- `op`, in, 1: 0 = ADD, 1 = NOT; sampled with `start`.
- `a`, in, N, signed: operand A. Used by NOT and ADD; sampled with `start`.
- `b`, in, N, signed: operand B. Used by ADD only; sampled with `start`.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `done`, out, 1: one-cycle pulse; results are valid in this cycle.
- `not_res`, out, N: ~a, feeds mux `in1`.
- `add_res`, out, N: a+b mod 2^N, feeds mux `in2`.
- `sel`, out, 1: 1 = NOT, 0 = ADD; feeds mux `select`.
- `cout`, out, 1: unsigned carry out of the ADD.
- `ovf`, out, 1: signed overflow of the ADD.

## Operation
- States and transitions:
  - IDLE → NOT_DONE on `start`&&`op`.
  - IDLE → ADD on `start`&&!`op`.
  - ADD → DONE when the bit counter reaches N−1.
  - NOT_DONE and DONE → IDLE unconditionally.
- IDLE, `start`, `op`=1: `not_res`<=~a, `sel`<=1. `add_res`, `cout` and `ovf` are unchanged.
- IDLE, `start`, `op`=0:
  - Load shift registers `sa`<=a and `sb`<=b.
  - Clear carry; `cnt`<=0; `sel`<=0.
  - Latch sign bits a[N-1] and b[N-1].
- ADD, each cycle:
  - s = sa[0]^sb[0]^c; c <= majority(sa[0], sb[0], c).
  - `add_res` <= {s, add_res[N-1:1]}.
  - sa and sb shift right by 1; `cnt`++.
- Leaving ADD (last bit, cnt=N−1):
  - `cout`<=final carry.
  - `ovf` <= (signA==signB) && (s != signA), where s is the final sum bit.
- DONE and NOT_DONE: `done`=1 for exactly that cycle.
- Result holding:
  - All results hold their values until the next accepted `start` of the same op type overwrites them.
  - `sel` holds until the next accepted `start`.
  - `add_res` is intermediate and not meaningful during ADD; it is valid only from `done` onward.
- `start` while `busy`=1 (including the done cycle) is ignored with no side effects.
- Arithmetic wraps modulo 2^N. No saturation.

## Timing
- Reset values: `busy`=0, `done`=0, `not_res`=0, `add_res`=0, `sel`=0, `cout`=0, `ovf`=0; state=IDLE; `cnt`=0.
- Reset asserted mid-operation: returns to IDLE immediately and asynchronously. No `done` is produced. The first `start` after deassertion behaves normally.
- NOT latency: `start` sampled at edge t; `done`=1 in cycle t+1; `busy`=1 only in cycle t+1.
- ADD latency:
  - `start` sampled at edge t.
  - `busy`=1 for cycles t+1 … t+N+1.
  - `done`=1 in cycle t+N+1.
- Back-to-back operation: the earliest next accepted `start` is the cycle after `done`.
- Throughput: 1 op per 2 cycles (NOT), 1 op per N+2 cycles (ADD).

## Structure
- Shared package `alu_stage_pkg` holds:
  - state encoding localparams: IDLE, ADD, DONE, NOT_DONE;
  - op codes OP_ADD=0, OP_NOT=1.
- `cnt` width is $clog2(N).
- One sub-module: `full_adder` (1-bit; a, b, cin → s, cout), instantiated once for the serial path.

## Test plan
- NOT: a=32'h0000_00FF, op=1, start → `done` one cycle later; `not_res`=32'hFFFF_FF00; `sel`=1; `add_res` unchanged.
- ADD: a=5, b=7 → `done` exactly 33 cycles after the start edge; `add_res`=12, `cout`=0, `ovf`=0, `sel`=0.
- Unsigned wrap: a=32'hFFFF_FFFF, b=1 → `add_res`=0, `cout`=1, `ovf`=0.
- Signed overflow, positive: a=32'h7FFF_FFFF, b=1 → `add_res`=32'h8000_0000, `ovf`=1, `cout`=0.
- Signed overflow, negative: a=32'h8000_0000, b=32'h8000_0000 → `add_res`=0, `ovf`=1, `cout`=1.
- Busy and reset:
  - Pulse `start` with op=1 during cycle 5 of an ADD → ignored; the ADD result is correct and `sel`=0.
  - Assert `rst` during cycle 10 of an ADD → all outputs are 0 immediately and no `done` appears.
  - Issue ADD 3+4 after reset → `add_res`=7.
